button_input_conditioner: RTL and testbench

Parametrised multi-channel front end for the board's push-buttons and switches, placed between the raw pins and the CPU platform's input port. Each channel is synchronised, optionally inverted, and debounced. Each channel also produces single-cycle press, release and auto-repeat pulses, plus a long-press "held" level. Sticky per-channel event flags let software poll for presses and clear them explicitly, so presses are not lost between polls.

---
 rtl/button_input_conditioner.sv | 158 +++++++++++++++
 tb/tb_button_input_conditioner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_input_conditioner.sv
// Multi-channel push-button front end: sync, invert, debounce,
// press/release/hold/repeat pulses and sticky event flags.
module button_input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] buttons_raw,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] held,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic [CHANNELS-1:0] events
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST =
    RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic [CHANNELS-1:0] pin;
  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  assign pin = (ACTIVE_LOW != 0) ? ~buttons_raw : buttons_raw;

  // Synchroniser resets to the not-pressed value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DW-1:0] db_q, db_d;
    logic          deb_q, deb_d;
    state_t        st_q, st_d;
    logic [HW-1:0] h_q, h_d;
    logic [RW-1:0] r_q, r_d;
    logic          press_d, rel_d, held_d, rep_d, evt_d;
    logic          lvl_q, press_q, rel_q, held_q, rep_q, evt_q;

    always_comb begin
      db_d  = '0;
      deb_d = deb_q;
      if (sync2[i] != deb_q) begin
        if (db_q == DB_LAST) begin
          deb_d = ~deb_q;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
    end

    // Release wins over any hold or repeat due the same cycle
    always_comb begin
      st_d    = st_q;
      h_d     = h_q;
      r_d     = r_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rep_d   = 1'b0;
      unique case (st_q)
        IDLE: begin
          if (deb_q) begin
            st_d    = PRESSED;
            press_d = 1'b1;
            h_d     = '0;
          end
        end
        PRESSED: begin
          if (!deb_q) begin
            st_d  = IDLE;
            rel_d = 1'b1;
          end else if (h_q == HOLD_LAST) begin
            st_d  = HELD;
            rep_d = 1'b1;
            r_d   = '0;
          end else begin
            h_d = h_q + 1'b1;
          end
        end
        HELD: begin
          if (!deb_q) begin
            st_d  = IDLE;
            rel_d = 1'b1;
          end else if (REPEAT_CYCLES > 0) begin
            if (r_q == REP_LAST) begin
              rep_d = 1'b1;
              r_d   = '0;
            end else begin
              r_d = r_q + 1'b1;
            end
          end
        end
        default: st_d = IDLE;
      endcase
      held_d = (st_d == HELD);
      evt_d  = (evt_q & ~clear[i]) | press_d | rep_d;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db_q    <= '0;
        deb_q   <= 1'b0;
        st_q    <= IDLE;
        h_q     <= '0;
        r_q     <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        held_q  <= 1'b0;
        rep_q   <= 1'b0;
        evt_q   <= 1'b0;
      end else begin
        db_q    <= db_d;
        deb_q   <= deb_d;
        st_q    <= st_d;
        h_q     <= h_d;
        r_q     <= r_d;
        lvl_q   <= deb_q;
        press_q <= press_d;
        rel_q   <= rel_d;
        held_q  <= held_d;
        rep_q   <= rep_d;
        evt_q   <= evt_d;
      end
    end

    assign level[i]         = lvl_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign held[i]          = held_q;
    assign repeat_pulse[i]  = rep_q;
    assign events[i]        = evt_q;
  end

endmodule

// File: tb/tb_button_input_conditioner.sv
// Scoreboard bench for button_input_conditioner (4 ch, fast timing).
module tb_button_input_conditioner;

  localparam int CH = 4;
  localparam int DB = 4;
  localparam int HC = 10;
  localparam int RC = 3;
  localparam int NEVER = 1 << 20;

  typedef logic [23:0] vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] buttons_raw;
  logic [CH-1:0] clear;
  logic [CH-1:0] level;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] held;
  logic [CH-1:0] repeat_pulse;
  logic [CH-1:0] events;

  int   tests = 0;
  int   fails = 0;
  vec_t exp_q[$];
  logic [CH-1:0] ev_m;
  int   p_e[CH];
  int   r_e[CH];

  always #5 clk = ~clk;

  button_input_conditioner #(
    .CHANNELS(CH),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HC),
    .REPEAT_CYCLES(RC),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .buttons_raw(buttons_raw),
    .clear(clear),
    .level(level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .held(held),
    .repeat_pulse(repeat_pulse),
    .events(events)
  );

  function automatic vec_t outs();
    return {level, press_pulse, release_pulse, held, repeat_pulse, events};
  endfunction

  // Expected {level,press,release,held,repeat} at edge e for one press
  function automatic logic [4:0] chan(int e, int p, int r);
    int pe, re, he;
    logic lv, pp, rp, hd, rep;
    pe  = p + 2 + DB;
    re  = (r >= NEVER) ? NEVER : r + 2 + DB;
    he  = pe + HC;
    lv  = (e >= pe) && (e < re);
    pp  = (e == pe);
    rp  = (e == re);
    hd  = (e >= he) && (e < re);
    rep = hd && (((e - he) % RC) == 0);
    return {lv, pp, rp, hd, rep};
  endfunction

  function automatic logic [CH-1:0] raw_for(int e);
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++)
      v[c] = !((e >= p_e[c]) && (e < r_e[c]));
    return v;
  endfunction

  task automatic push_exp(input int e, input logic [CH-1:0] clr);
    logic [4:0] c;
    logic [CH-1:0] lv, pp, rp, hd, rep;
    for (int k = 0; k < CH; k++) begin
      c = chan(e, p_e[k], r_e[k]);
      lv[k]  = c[4];
      pp[k]  = c[3];
      rp[k]  = c[2];
      hd[k]  = c[1];
      rep[k] = c[0];
    end
    ev_m = (ev_m & ~clr) | pp | rep;
    exp_q.push_back({lv, pp, rp, hd, rep, ev_m});
  endtask

  task automatic idle_all();
    for (int k = 0; k < CH; k++) begin
      p_e[k] = NEVER;
      r_e[k] = NEVER;
    end
  endtask

  task automatic test_reset();
    vec_t got, want;
    idle_all();
    ev_m = '0;
    reset = 1'b1;
    buttons_raw = '1;
    clear = '0;
    repeat (3) @(posedge clk);
    #1;
    got = outs();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_hold got=%h want=%h", got, 24'h0);
    end
    reset = 1'b0;
    for (int e = 0; e < 20; e++) begin
      buttons_raw = raw_for(e);
      push_exp(e, clear);
      @(posedge clk);
      #1;
      got = outs();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_idle e=%0d got=%h want=%h", e, got, want);
      end
    end
  endtask

  task automatic test_press();
    vec_t got, want;
    idle_all();
    p_e[0] = 0;
    r_e[0] = 8;
    for (int e = 0; e < 20; e++) begin
      buttons_raw = raw_for(e);
      push_exp(e, clear);
      @(posedge clk);
      #1;
      got = outs();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL press_ch0 e=%0d got=%h want=%h", e, got, want);
      end
    end
  endtask

  task automatic test_bounce();
    vec_t got, want;
    idle_all();
    for (int e = 0; e < 16; e++) begin
      buttons_raw = raw_for(e);
      buttons_raw[1] = !(e < 3 || (e >= 4 && e < 7));
      push_exp(e, clear);
      @(posedge clk);
      #1;
      got = outs();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL bounce_ch1 e=%0d got=%h want=%h", e, got, want);
      end
    end
  endtask

  task automatic test_long_press();
    vec_t got, want;
    idle_all();
    p_e[2] = 0;
    r_e[2] = 23;
    for (int e = 0; e < 36; e++) begin
      buttons_raw = raw_for(e);
      push_exp(e, clear);
      @(posedge clk);
      #1;
      got = outs();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL hold_ch2 e=%0d got=%h want=%h", e, got, want);
      end
    end
  endtask

  task automatic test_events();
    vec_t got, want;
    idle_all();
    p_e[3] = 0;
    r_e[3] = 24;
    for (int e = 0; e < 38; e++) begin
      buttons_raw = raw_for(e);
      clear = '0;
      clear[3] = (e == 8) || (e == 19) || (e == 20);
      push_exp(e, clear);
      @(posedge clk);
      #1;
      got = outs();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL events_ch3 e=%0d got=%h want=%h", e, got, want);
      end
    end
    clear = '0;
  endtask

  task automatic test_reset_mid();
    vec_t got, want;
    idle_all();
    p_e[0] = 0;
    for (int e = 0; e < 18; e++) begin
      buttons_raw = raw_for(e);
      push_exp(e, clear);
      @(posedge clk);
      #1;
      got = outs();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL prehold_ch0 e=%0d got=%h want=%h", e, got, want);
      end
    end
    reset = 1'b1;
    #2;
    got = outs();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_async got=%h want=%h", got, 24'h0);
    end
    @(posedge clk);
    #1;
    got = outs();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_mid got=%h want=%h", got, 24'h0);
    end
    reset = 1'b0;
    ev_m = '0;
    for (int e = 0; e < 12; e++) begin
      buttons_raw = raw_for(e);
      push_exp(e, clear);
      @(posedge clk);
      #1;
      got = outs();
      want = exp_q.pop_front();
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL repress_ch0 e=%0d got=%h want=%h", e, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_long_press();
    test_events();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
